// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with per-slot blanking and a
// shadow register that commits new display values only at frame boundaries.
module ssd_scan_ctrl #(
  parameter int DIGITS       = 2,
  parameter int SCAN_DIV     = 4096,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_value,
  input  logic [DIGITS-1:0]     in_blank,
  output logic [6:0]            out_seg,
  output logic [DIGITS-1:0]     out_dig,
  output logic                  frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]     BLANK_LIM = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_ONE   = DIGITS'(1);

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

  // With no blanking gap every slot is driven from its first cycle.
  localparam phase_t PH_RST = (BLANK_CYCLES == 0) ? PH_DRIVE : PH_BLANK;

  phase_t              phase, phase_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       idx, idx_n;
  logic [4*DIGITS-1:0] disp_val, disp_val_n, sh_val, sh_val_n;
  logic [DIGITS-1:0]   disp_blank, disp_blank_n, sh_blank, sh_blank_n;
  logic                pending, pending_n;
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   dig_n;
  logic                slot_wrap, frame_wrap, xfer, blk;
  logic [3:0]          nib;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign in_ready = !pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase       <= PH_RST;
      cnt         <= '0;
      idx         <= '0;
      disp_val    <= '0;
      disp_blank  <= '0;
      sh_val      <= '0;
      sh_blank    <= '0;
      pending     <= 1'b0;
      out_seg     <= 7'h7F;
      out_dig     <= '0;
      frame_start <= 1'b0;
    end else begin
      phase       <= phase_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      disp_val    <= disp_val_n;
      disp_blank  <= disp_blank_n;
      sh_val      <= sh_val_n;
      sh_blank    <= sh_blank_n;
      pending     <= pending_n;
      out_seg     <= seg_n;
      out_dig     <= dig_n;
      frame_start <= frame_wrap;
    end
  end

  always_comb begin
    slot_wrap    = (cnt == CNT_LAST);
    frame_wrap   = slot_wrap && (idx == IDX_LAST);
    xfer         = in_valid && !pending;
    cnt_n        = slot_wrap ? '0 : cnt + CW'(1);
    idx_n        = idx;
    phase_n      = phase;
    disp_val_n   = disp_val;
    disp_blank_n = disp_blank;
    sh_val_n     = sh_val;
    sh_blank_n   = sh_blank;
    pending_n    = pending;
    nib          = '0;
    blk          = 1'b1;
    seg_n        = 7'h7F;
    dig_n        = '0;

    if (slot_wrap)
      idx_n = (idx == IDX_LAST) ? '0 : idx + IW'(1);

    unique case (phase)
      PH_BLANK: if (cnt_n == BLANK_LIM) phase_n = PH_DRIVE;
      default:  if (slot_wrap && BLANK_CYCLES != 0) phase_n = PH_BLANK;
    endcase

    // A transfer landing on the boundary edge itself goes straight to the
    // display, so it still shows in the frame that starts there.
    if (frame_wrap && pending) begin
      disp_val_n   = sh_val;
      disp_blank_n = sh_blank;
      pending_n    = 1'b0;
    end else if (frame_wrap && xfer) begin
      disp_val_n   = in_value;
      disp_blank_n = in_blank;
    end else if (xfer) begin
      sh_val_n     = in_value;
      sh_blank_n   = in_blank;
      pending_n    = 1'b1;
    end

    for (int i = 0; i < DIGITS; i++) begin
      if (idx_n == IW'(i)) begin
        nib = disp_val_n[4*i +: 4];
        blk = disp_blank_n[i];
      end
    end

    // Outputs are registered from next-state values so they line up with cnt/idx.
    if (phase_n == PH_DRIVE && !blk) begin
      seg_n = decode(nib);
      dig_n = DIG_ONE << idx_n;
    end
  end

endmodule
